// File: rtl/mdu_sequencer.sv
// mdu_sequencer: multi-cycle multiply/divide sequencer.
// op: 00 MULTU, 01 MULT, 10 DIVU, 11 DIV. The sequencer does not contain an
// adder. Every add and subtract is issued to an external ALU through
// alu_a/alu_b/alu_control, and the sum comes back on alu_c/alu_carry.
// Multiply uses shift-add. Divide uses restoring division. Signed operations
// work on magnitudes and fix the signs in a final cycle.
// ALU encoding on alu_control: 0 NONE, 1 ADDU, 2 SUBU.

typedef enum logic [1:0] {
  ALU_NONE = 2'd0,
  ALU_ADDU = 2'd1,
  ALU_SUBU = 2'd2
} AluCodeEnum;

module mdu_sequencer #(
  parameter int BitWidth = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [1:0]          op,
  input  logic [BitWidth-1:0] a,
  input  logic [BitWidth-1:0] b,
  output logic                busy,
  output logic                done,
  output logic [BitWidth-1:0] hi,
  output logic [BitWidth-1:0] lo,
  output logic                div_by_zero,
  output logic [BitWidth-1:0] alu_a,
  output logic [BitWidth-1:0] alu_b,
  output AluCodeEnum          alu_control,
  input  logic [BitWidth-1:0] alu_c,
  input  logic                alu_carry
);

  localparam int CntW = $clog2(BitWidth) + 1;
  localparam logic [CntW-1:0] LastIter = CntW'(BitWidth - 1);

  typedef enum logic [2:0] {IDLE, PREP, ITER, FIX, DONE} state_e;

  state_e                state_q, state_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic [BitWidth-1:0]   p_q, p_d;     // multiply accumulator / divide remainder
  logic [BitWidth-1:0]   q_q, q_d;     // multiplier / dividend, becomes low product / quotient
  logic [BitWidth-1:0]   md_q, md_d;   // multiplicand / divisor
  logic [BitWidth-1:0]   a_q, a_d;     // original a, kept for signs and divide-by-zero
  logic [1:0]            op_q, op_d;
  logic                  sb_q, sb_d;   // original sign of b
  logic [BitWidth-1:0]   hi_q, hi_d;
  logic [BitWidth-1:0]   lo_q, lo_d;
  logic                  dbz_q, dbz_d;

  logic                  is_div, signed_op, neg_a, neg_b, neg_res;
  logic [BitWidth-1:0]   rem_shift;
  logic [2*BitWidth-1:0] prod, prod_fix;

  assign is_div    = op_q[1];
  assign signed_op = op_q[0];
  assign neg_a     = signed_op & a_q[BitWidth-1];
  assign neg_b     = signed_op & sb_q;
  assign neg_res   = neg_a ^ neg_b;
  assign rem_shift = {p_q[BitWidth-2:0], q_q[BitWidth-1]};
  assign prod      = {p_q, q_q};
  assign prod_fix  = neg_res ? -prod : prod;

  assign busy        = (state_q != IDLE);
  assign done        = (state_q == DONE);
  assign hi          = hi_q;
  assign lo          = lo_q;
  assign div_by_zero = dbz_q;

  // Next-state, datapath and ALU request logic
  always_comb begin
    // NOTE: every signal written here gets a default first. Then no path
    // leaves a signal unassigned, and no latch is inferred.
    state_d     = state_q;
    cnt_d       = cnt_q;
    p_d         = p_q;
    q_d         = q_q;
    md_d        = md_q;
    a_d         = a_q;
    op_d        = op_q;
    sb_d        = sb_q;
    hi_d        = hi_q;
    lo_d        = lo_q;
    dbz_d       = dbz_q;
    alu_control = ALU_NONE;
    alu_a       = '0;
    alu_b       = '0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = a;
          md_d    = b;
          op_d    = op;
          sb_d    = b[BitWidth-1];
          dbz_d   = 1'b0;
          state_d = PREP;
        end
      end
      PREP: begin
        p_d     = '0;
        q_d     = neg_a ? -a_q : a_q;
        md_d    = neg_b ? -md_q : md_q;
        cnt_d   = '0;
        state_d = ITER;
      end
      ITER: begin
        if (!is_div) begin
          alu_control = ALU_ADDU;
          alu_a       = p_q;
          alu_b       = q_q[0] ? md_q : '0;
          p_d         = {alu_carry, alu_c[BitWidth-1:1]};
          q_d         = {alu_c[0], q_q[BitWidth-1:1]};
        end else begin
          alu_control = ALU_SUBU;
          alu_a       = rem_shift;
          alu_b       = md_q;
          // A set R MSB means the shifted remainder overflowed the width,
          // so the divisor always fits, even if the ALU reports a borrow.
          if (p_q[BitWidth-1] || !alu_carry) begin
            p_d = alu_c;
            q_d = {q_q[BitWidth-2:0], 1'b1};
          end else begin
            p_d = rem_shift;
            q_d = {q_q[BitWidth-2:0], 1'b0};
          end
        end
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LastIter) state_d = FIX;
      end
      FIX: begin
        if (!is_div) begin
          hi_d = prod_fix[2*BitWidth-1:BitWidth];
          lo_d = prod_fix[BitWidth-1:0];
        end else if (md_q == '0) begin
          hi_d  = a_q;
          lo_d  = '1;
          dbz_d = 1'b1;
        end else begin
          // The quotient follows the product sign, and the remainder follows
          // the dividend. MIN / -1 wraps back to MIN, which is the intended result.
          hi_d = neg_a ? -p_q : p_q;
          lo_d = neg_res ? -q_q : q_q;
        end
        state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments only. Every register samples
    // pre-edge values, whatever order the statements are in.
    if (reset) begin
      // NOTE: the datapath registers are cleared as well as the FSM. This
      // way a reset leaves no trace of an aborted operation.
      state_q <= IDLE;
      cnt_q   <= '0;
      p_q     <= '0;
      q_q     <= '0;
      md_q    <= '0;
      a_q     <= '0;
      op_q    <= '0;
      sb_q    <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      p_q     <= p_d;
      q_q     <= q_d;
      md_q    <= md_d;
      a_q     <= a_d;
      op_q    <= op_d;
      sb_q    <= sb_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      dbz_q   <= dbz_d;
    end
  end

endmodule

// File: doc/mdu_sequencer.md
MDU_SEQUENCER -- requirements
Module: mdu_sequencer

Interface
REQ-001 SHALL have parameter: BitWidth, 32, operand/result width (even, >=4).
REQ-002 SHALL have port: clk  input  1  sole clock, all state updates on rising edge.
REQ-003 SHALL have port: reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port: start  input  1  request; sampled only in IDLE.
REQ-005 SHALL have port: op  input  2  00 MULTU, 01 MULT, 10 DIVU, 11 DIV.
REQ-006 SHALL have ports: a, b  input  BitWidth  operands, captured when start is accepted.
REQ-007 SHALL have port: busy  output  1  high in every state except IDLE.
REQ-008 SHALL have port: done  output  1  one-cycle pulse, results valid.
REQ-009 SHALL have ports: hi, lo  output  BitWidth  product high/low, or remainder/quotient.
REQ-010 SHALL have port: div_by_zero  output  1  set with done when a divide has b==0.
REQ-011 SHALL have ports: alu_a, alu_b  output  BitWidth  operands to the shared ALU.
REQ-012 SHALL have port: alu_control  output  AluCodeEnum  ALU operation select.
REQ-013 SHALL have ports: alu_c  input  BitWidth, and alu_carry  input  1  ALU result and carry; on SUBU, carry=1 means borrow (alu_a < alu_b unsigned).

Function
REQ-014 SHALL implement FSM IDLE->PREP->ITER->FIX->DONE->IDLE; start=1 in IDLE is accepted at cycle 0.
REQ-015 SHALL ignore start in any state other than IDLE; operands and op SHALL NOT change mid-operation.
REQ-016 PREP (1 cycle) SHALL latch magnitudes: |a| and |b| for MULT/DIV (two's complement negate if MSB set), raw a and b for MULTU/DIVU; SHALL clear the accumulator/remainder P.
REQ-017 ITER SHALL last exactly BitWidth cycles, counted by an internal counter of width ceil(log2(BitWidth))+1.
REQ-018 Multiply iteration: alu_control=ADDU, alu_a=P, alu_b = Q[0] ? M : 0; next {P,Q} = {alu_carry, alu_c, Q[BitWidth-1:1]}.
REQ-019 Divide iteration: alu_control=SUBU, alu_a={R[BitWidth-2:0],Q[BitWidth-1]}, alu_b=D; if R[BitWidth-1]==1 or alu_carry==0 then R<=alu_c and shift in quotient bit 1, else R<=alu_a and shift in 0.
REQ-020 FIX (1 cycle): MULT negates the 2*BitWidth product when sign(a)^sign(b); DIV negates the quotient when sign(a)^sign(b), and the remainder takes sign(a); unsigned ops pass through.
REQ-021 Divide by zero (b==0, DIVU or DIV): iterations still run; FIX SHALL force hi=a (original), lo=all ones, div_by_zero=1.
REQ-022 DIV of most-negative by -1 SHALL yield lo=most-negative, hi=0, div_by_zero=0.
REQ-023 DONE (1 cycle) SHALL assert done=1; done SHALL rise exactly BitWidth+3 cycles after the accepting edge.
REQ-024 hi, lo and div_by_zero SHALL update only in FIX and SHALL hold until the next FIX; div_by_zero SHALL be cleared at the accepting edge.
REQ-025 Outside ITER: alu_control=NONE and alu_a=alu_b=0.
REQ-026 Sign-magnitude negation and the shift of P/Q/R SHALL use internal logic; all add/subtract steps SHALL go through the ALU ports.
REQ-027 A start in the cycle done is high SHALL be ignored; it is accepted on the following IDLE cycle.

Reset
REQ-028 reset=1 SHALL, at the next rising edge, force state IDLE, busy=0, done=0, div_by_zero=0, hi=lo=0, internal P/Q/R/M/D/counter=0, regardless of state.
REQ-029 reset SHALL take priority over start in the same cycle; an operation interrupted mid-ITER SHALL produce no done.

Verification
REQ-030 MULTU 0xFFFFFFFF*0xFFFFFFFF -> done at cycle 35, hi=0xFFFFFFFE, lo=0x00000001.
REQ-031 MULT -3*7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB; MULT -1*-1 -> hi=0, lo=1.
REQ-032 DIV -7/2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIVU 0xFFFFFFFF/0x10 -> lo=0x0FFFFFFF, hi=0xF.
REQ-033 DIVU 5/0 -> div_by_zero=1, hi=5, lo=0xFFFFFFFF; DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0, div_by_zero=0.
REQ-034 Start pulses at cycles 3 and 20 during one operation -> single done at cycle 35, result of first operands only.
REQ-035 reset asserted at ITER cycle 10 -> next cycle busy=0, hi=lo=0, alu_control=NONE, no done; new start then completes normally.
